// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage feeding the IF/ID register. Owns the program counter, issues
//   reads to a 1-cycle-latency instruction memory and buffers the returned
//   {pc, instruction} pairs in a small in-order queue. A redirect flushes the
//   queue, drops any response landing that cycle and fetches the new target
//   in the same cycle.
//
// Ports
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   redirect_valid/pc : taken branch/jump and its target (bits [1:0] ignored)
//   imem_req/addr     : combinational read request and address
//   imem_rdata        : read data, valid the cycle after imem_req
//   out_valid/ready   : handshake towards IF/ID (ready low = stall)
//   PC_out            : pc of the queue head (0 when empty)
//   Instruction       : instruction word of the queue head (0 when empty)

module instruction_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] PC_out,
   output logic [31:0] Instruction
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [63:0]   pc_q, pc_d;
   logic [63:0]   req_pc_q, req_pc_d;
   logic          inflight_q, inflight_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [63:0]   mem_pc_q [DEPTH];
   logic [63:0]   mem_pc_d [DEPTH];
   logic [31:0]   mem_ins_q [DEPTH];
   logic [31:0]   mem_ins_d [DEPTH];

   logic          deq;
   logic          push;
   logic [CW:0]   occupancy;
   logic          issue_ok;
   logic [63:0]   redirect_addr;

   // Low target bits are dropped by forcing alignment.
   logic unused_redirect_lsb;
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   always_comb begin
      out_valid     = (count_q != '0);
      // Dequeue is meaningless in a redirect cycle: the whole queue goes.
      deq           = out_valid & out_ready & ~redirect_valid;
      push          = inflight_q;
      // Slots already committed (queued + in flight) after this cycle's pop.
      // deq implies count >= 1, so this never underflows.
      occupancy     = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, deq};
      issue_ok      = (occupancy < (CW+1)'(DEPTH));
      redirect_addr = {redirect_pc[63:2], 2'b00};

      PC_out        = out_valid ? mem_pc_q[rd_ptr_q]  : 64'h0;
      Instruction   = out_valid ? mem_ins_q[rd_ptr_q] : 32'h0;

      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = 1'b0;
      count_d    = count_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      mem_pc_d   = mem_pc_q;
      mem_ins_d  = mem_ins_q;
      imem_req   = 1'b0;
      imem_addr  = pc_q;

      if (reset) begin
         pc_d       = RESET_PC;
         inflight_d = 1'b0;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else if (redirect_valid) begin
         imem_req   = 1'b1;
         imem_addr  = redirect_addr;
         pc_d       = redirect_addr + 64'd4;
         req_pc_d   = redirect_addr;
         inflight_d = 1'b1;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         imem_req  = issue_ok;
         imem_addr = pc_q;
         if (issue_ok) begin
            pc_d       = pc_q + 64'd4;
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
         end
         if (push) begin
            mem_pc_d[wr_ptr_q]  = req_pc_q;
            mem_ins_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d            = wr_ptr_q + PW'(1);
         end
         if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push) - CW'(deq);
      end
   end

   always_ff @(posedge clk) begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      mem_pc_q   <= mem_pc_d;
      mem_ins_q  <= mem_ins_d;
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
//   Drives instruction_fetch against a 1-cycle memory returning addr[31:0].
//   Expected program-order pcs sit in a queue rebuilt on reset/redirect and
//   are popped on each accepted output. A second instance starts at the top
//   of the address space to show pc wrap.

module tb_instruction_fetch;

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] PC_out;
   logic [31:0] Instruction;

   logic        w_imem_req;
   logic [63:0] w_imem_addr;
   logic [31:0] w_imem_rdata;
   logic        w_out_valid;
   logic [63:0] w_PC_out;
   logic [31:0] w_Instruction;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_q [$];

   instruction_fetch #(.RESET_PC(64'h1000), .DEPTH(2)) u_dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .PC_out(PC_out), .Instruction(Instruction)
   );

   instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .DEPTH(2)) u_wrap (
      .clk(clk), .reset(reset),
      .redirect_valid(1'b0), .redirect_pc(64'h0),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
      .out_valid(w_out_valid), .out_ready(1'b1),
      .PC_out(w_PC_out), .Instruction(w_Instruction)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory; junk when not requested so stray pushes show up.
   always @(posedge clk) begin
      imem_rdata   <= imem_req   ? imem_addr[31:0]   : 32'hDEAD_BEEF;
      w_imem_rdata <= w_imem_req ? w_imem_addr[31:0] : 32'hDEAD_BEEF;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic sb_restart(input logic [63:0] base);
      exp_q.delete();
      for (int i = 0; i < 48; i++) exp_q.push_back(base + 64'(4 * i));
   endtask

   task automatic settle();
      #1;
   endtask

   // Score the accepted head (if any), then advance to just after the next edge.
   task automatic tick();
      logic [63:0] e;
      if (!reset && !redirect_valid && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_underflow", PC_out, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("sb_pc", PC_out, e);
            chk("sb_ins", {32'h0, Instruction}, {32'h0, e[31:0]});
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      out_ready      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      settle();
      chk("rst_req",   imem_req,    0);
      chk("rst_valid", out_valid,   0);
      chk("rst_pc",    PC_out,      0);
      chk("rst_ins",   Instruction, 0);
      tick();

      // streaming from reset
      reset = 1'b0;
      sb_restart(64'h1000);
      settle();
      chk("c0_req",  imem_req,  1);
      chk("c0_addr", imem_addr, 64'h1000);
      chk("w0_addr", w_imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      tick();
      settle();
      chk("c1_valid", out_valid, 0);
      chk("c1_addr",  imem_addr, 64'h1004);
      chk("w1_addr",  w_imem_addr, 64'h0);
      tick();
      settle();
      chk("c2_valid", out_valid, 1);
      chk("c2_pc",    PC_out, 64'h1000);
      chk("w2_pc",    w_PC_out, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("w2_ins",   w_Instruction, 64'hFFFF_FFFC);
      tick();
      settle();
      chk("c3_pc",  PC_out, 64'h1004);
      chk("w3_valid", w_out_valid, 1);
      chk("w3_pc",  w_PC_out, 64'h0);
      chk("w3_ins", w_Instruction, 64'h0);
      tick();

      // stall with head 0x1008
      for (int i = 0; i < 5; i++) begin
         out_ready = 1'b0;
         settle();
         chk("stall_req",   imem_req,  0);
         chk("stall_valid", out_valid, 1);
         chk("stall_pc",    PC_out,    64'h1008);
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         settle();
         chk("rel_valid", out_valid, 1);
         tick();
      end

      // redirect while streaming (one queued, one in flight)
      redirect_valid = 1'b1;
      redirect_pc    = 64'h2000;
      sb_restart(64'h2000);
      settle();
      chk("r1_req",  imem_req,  1);
      chk("r1_addr", imem_addr, 64'h2000);
      tick();
      redirect_valid = 1'b0;
      settle();
      chk("r1_flush", out_valid, 0);
      tick();
      settle();
      chk("r1_valid", out_valid, 1);
      chk("r1_pc",    PC_out, 64'h2000);
      for (int i = 0; i < 4; i++) begin
         settle();
         tick();
      end

      // redirect together with a stall, misaligned target
      redirect_valid = 1'b1;
      redirect_pc    = 64'h3003;
      out_ready      = 1'b0;
      sb_restart(64'h3000);
      settle();
      chk("r2_req",  imem_req,  1);
      chk("r2_addr", imem_addr, 64'h3000);
      tick();
      redirect_valid = 1'b0;
      out_ready      = 1'b1;
      settle();
      chk("r2_flush", out_valid, 0);
      tick();
      settle();
      chk("r2_pc0", PC_out, 64'h3000);
      tick();
      settle();
      chk("r2_pc1", PC_out, 64'h3004);
      tick();
      for (int i = 0; i < 3; i++) begin
         settle();
         tick();
      end

      // reset mid-stream while a read is outstanding
      out_ready = 1'b0;
      reset     = 1'b1;
      settle();
      chk("mr_req", imem_req, 0);
      tick();
      reset     = 1'b0;
      out_ready = 1'b1;
      sb_restart(64'h1000);
      settle();
      chk("mr_valid", out_valid, 0);
      chk("mr_pc",    PC_out,    0);
      chk("mr_req1",  imem_req,  1);
      chk("mr_addr",  imem_addr, 64'h1000);
      tick();
      settle();
      chk("mr_valid1", out_valid, 0);
      tick();
      settle();
      chk("mr_first", PC_out, 64'h1000);
      for (int i = 0; i < 8; i++) begin
         settle();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
